// File: rtl/uart_pattern_gen.sv
// uart_pattern_gen: 8N1 UART transmitter cycling FIRST_CHAR..LAST_CHAR; CR/LF line terminators under `UART_PATGEN_CRLF_EN
module uart_pattern_gen #(
   parameter int         CLK_FREQ        = 25_000_000,
   parameter int         BAUD_RATE       = 9600,
   parameter int         INTERVAL_CYCLES = 12_500_000,
   parameter logic [7:0] FIRST_CHAR      = 8'h41,
   parameter logic [7:0] LAST_CHAR       = 8'h5A,
   parameter int         LINE_LEN        = 26
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        burst,
   output logic        tx,
   output logic        busy,
   output logic [7:0]  cur_char,
   output logic [15:0] char_count
);
   localparam int DIV = CLK_FREQ / BAUD_RATE;
   localparam int CW  = $clog2(DIV);
   localparam int TW  = $clog2(INTERVAL_CYCLES + 1);

   if (DIV < 2 || INTERVAL_CYCLES < 1 || FIRST_CHAR > LAST_CHAR || LINE_LEN < 1) begin : g_param_check
      $error("uart_pattern_gen: illegal parameter set");
   end

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_START, S_DATA, S_STOP} state_e;

   state_e        state_q;
   logic [CW-1:0] div_q;
   logic [2:0]    bit_q;
   logic [TW-1:0] tmr_q;
   logic [7:0]    sh_q;
   logic [7:0]    cur_q;
   logic [15:0]   cnt_q;
   logic          tx_q;
   logic          busy_q;
   logic          div_end;
   logic [7:0]    nxt_char;
   logic [7:0]    frame_byte;

   assign div_end  = div_q == CW'(DIV - 1);
   assign nxt_char = cur_q == LAST_CHAR ? FIRST_CHAR : cur_q + 8'd1;

`ifdef UART_PATGEN_CRLF_EN
   localparam int LW = $clog2(LINE_LEN + 1);
   logic [LW-1:0] line_q;
   logic [1:0]    term_q;
   logic          line_end;
   assign line_end   = line_q == LW'(LINE_LEN - 1);
   assign frame_byte = term_q == 2'd1 ? 8'h0D : term_q == 2'd2 ? 8'h0A : cur_q;
`else
   assign frame_byte = cur_q;
`endif

   // Frame sequencer: one registered FSM owns tx, busy, pattern position and counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         tmr_q   <= '0;
         sh_q    <= '0;
         cur_q   <= FIRST_CHAR;
         cnt_q   <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
`ifdef UART_PATGEN_CRLF_EN
         line_q  <= '0;
         term_q  <= 2'd0;
`endif
      end else begin
         if (state_q == S_START || state_q == S_DATA || state_q == S_STOP)
            div_q <= div_end ? '0 : div_q + CW'(1);
         case (state_q)
            S_IDLE: if (enable) begin
               state_q <= S_WAIT;
               tmr_q   <= '0;
            end
            S_WAIT: if (!enable) state_q <= S_IDLE;
            else if (burst || tmr_q == TW'(INTERVAL_CYCLES)) begin
               state_q <= S_START;
               sh_q    <= frame_byte;
               tx_q    <= 1'b0;
               busy_q  <= 1'b1;
            end else tmr_q <= tmr_q + TW'(1);
            S_START: if (div_end) begin
               state_q <= S_DATA;
               bit_q   <= '0;
               tx_q    <= sh_q[0];
            end
            S_DATA: if (div_end) begin
               if (bit_q == 3'd7) begin
                  state_q <= S_STOP;
                  bit_q   <= '0;
                  tx_q    <= 1'b1;
               end else begin
                  bit_q <= bit_q + 3'd1;
                  tx_q  <= sh_q[1];
                  sh_q  <= sh_q >> 1;
               end
            end
            S_STOP: if (div_end) begin
               state_q <= enable ? S_WAIT : S_IDLE;
               tmr_q   <= '0;
               busy_q  <= 1'b0;
               cnt_q   <= cnt_q + 16'd1;
`ifdef UART_PATGEN_CRLF_EN
               if (term_q == 2'd0) begin
                  cur_q  <= nxt_char;
                  line_q <= line_end ? '0 : line_q + LW'(1);
                  term_q <= line_end ? 2'd1 : 2'd0;
               end else term_q <= term_q == 2'd1 ? 2'd2 : 2'd0;
`else
               cur_q <= nxt_char;
`endif
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign tx         = tx_q;
   assign busy       = busy_q;
   assign cur_char   = cur_q;
   assign char_count = cnt_q;
endmodule
